// File: rtl/store_narrow_unit_if.sv
// Store-narrow bus bundle: request handshake from the execute/memory stage
// plus the word-wide data RAM port and completion status.
//   slave  : view taken by store_narrow_unit (accepts requests, drives RAM)
//   master : view taken by the pipeline/RAM side (issues requests, returns rdata)
interface store_narrow_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [31:0]       data_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              busy;
  logic              err;

  modport slave (
    input  req_valid, addr, size, data_in, mem_rdata, mem_rvalid,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, busy, err
  );

  modport master (
    output req_valid, addr, size, data_in, mem_rdata, mem_rvalid,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, busy, err
  );
endinterface

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a 32-bit register value to byte/half/word and
// writes it into a word-addressed data RAM. Sub-word stores do a
// read-modify-write (RD -> WAIT -> WR -> DONE); word stores go straight to WR.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   bus (slave)     req_valid/req_ready/addr/size/data_in request handshake,
//                   mem_addr/mem_rd/mem_rdata/mem_rvalid/mem_wr/mem_wdata RAM
//                   port, done/busy/err status
// Parameters:
//   ADDR_W          byte-address width
//   BIG_ENDIAN      1 = MIPS big-endian lane mapping, 0 = little-endian
// Optional feature macro: STORE_NARROW_MISALIGN_TRAP_EN
//   defined   : misaligned half/word completes immediately with err, no access
//   undefined : err tied low, misaligned addresses are forced aligned

// One byte lane of the merge: take the new byte when enabled, else keep RAM data.
module store_narrow_lane #(
  parameter int VEC_W = 8
) (
  input  logic             be,
  input  logic [VEC_W-1:0] new_b,
  input  logic [VEC_W-1:0] old_b,
  output logic [VEC_W-1:0] mrg_b
);
  assign mrg_b = be ? new_b : old_b;
endmodule

module store_narrow_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  store_narrow_unit_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;
  state_t state, state_nxt;

  // Captured request (only the fields the merge still needs)
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic              byte_q;
  logic [15:0]       data_q;
  logic [31:0]       wdata_q;

  logic accept, is_word, trap;
  assign accept  = bus.req_valid && (state == S_IDLE);
  assign is_word = bus.size[1];   // 10 and 11 both behave as a word

`ifdef STORE_NARROW_MISALIGN_TRAP_EN
  logic err_q;
  assign trap = ((bus.size == 2'b01) && bus.addr[0]) ||
                (is_word && (bus.addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = trap ? S_DONE : (is_word ? S_WR : S_RD);
      S_RD:   state_nxt = S_WAIT;
      S_WAIT: if (bus.mem_rvalid) state_nxt = S_WR;
      S_WR:   state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.busy      = (state != S_IDLE);
    bus.mem_rd    = (state == S_RD);
    bus.mem_wr    = (state == S_WR);
    bus.done      = (state == S_DONE);
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
`ifdef STORE_NARROW_MISALIGN_TRAP_EN
    bus.err       = (state == S_DONE) && err_q;
`else
    bus.err       = 1'b0;
`endif
  end

  // ---------------- lane merge ----------------
  // Byte enables per 8-bit lane (lane k = bits [8k+7:8k]). Halfwords only
  // look at offset bit 1, which also forces a misaligned half aligned.
  logic [NUM_LANES-1:0] be;
  logic                 half_hi;
  always_comb begin
    half_hi = BIG_ENDIAN ? ~off_q[1] : off_q[1];
    if (byte_q) be = BIG_ENDIAN ? (4'b1000 >> off_q) : (4'b0001 << off_q);
    else        be = half_hi ? 4'b1100 : 4'b0011;
  end

  // Replicate the narrow value across all lanes; the enables pick the target.
  logic [NUM_LANES-1:0][VEC_W-1:0] rep_l, old_l, mrg_l;
  assign rep_l = byte_q ? {4{data_q[7:0]}} : {2{data_q}};
  assign old_l = bus.mem_rdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    store_narrow_lane #(.VEC_W(VEC_W)) u_lane (
      .be    (be[g]),
      .new_b (rep_l[g]),
      .old_b (old_l[g]),
      .mrg_b (mrg_l[g])
    );
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      off_q   <= '0;
      byte_q  <= 1'b0;
      data_q  <= '0;
      wdata_q <= '0;
`ifdef STORE_NARROW_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else if (accept) begin
      addr_q <= {bus.addr[ADDR_W-1:2], 2'b00};
      off_q  <= bus.addr[1:0];
      byte_q <= (bus.size == 2'b00);
      data_q <= bus.data_in[15:0];
      if (is_word) wdata_q <= bus.data_in;
`ifdef STORE_NARROW_MISALIGN_TRAP_EN
      err_q  <= trap;
`endif
    end else if ((state == S_WAIT) && bus.mem_rvalid) begin
      wdata_q <= mrg_l;
    end
  end
endmodule

// File: tb/tb_store_narrow_unit.sv
module tb_store_narrow_unit;
`ifdef STORE_NARROW_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  size = '0;
  logic [31:0] data_in = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_narrow_unit_if #(.ADDR_W(32)) ifb ();
  store_narrow_unit_if #(.ADDR_W(32)) ifl ();

  assign ifb.req_valid = req_valid;  assign ifl.req_valid = req_valid;
  assign ifb.addr = addr;            assign ifl.addr = addr;
  assign ifb.size = size;            assign ifl.size = size;
  assign ifb.data_in = data_in;      assign ifl.data_in = data_in;
  assign ifb.mem_rdata = mem_rdata;  assign ifl.mem_rdata = mem_rdata;
  assign ifb.mem_rvalid = mem_rvalid; assign ifl.mem_rvalid = mem_rvalid;

  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) u_be (.clk(clk), .rst(rst), .bus(ifb));
  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) u_le (.clk(clk), .rst(rst), .bus(ifl));

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_addr;
    logic [31:0] exp_be;
    logic [31:0] exp_le;
    bit          mis;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mk(logic [31:0] a, logic [1:0] s, logic [31:0] d, logic [31:0] r,
                              int l, logic [31:0] ea, logic [31:0] eb, logic [31:0] el, bit m);
    vec_t v;
    v.addr = a; v.size = s; v.data = d; v.rdata = r; v.lat = l;
    v.exp_addr = ea; v.exp_be = eb; v.exp_le = el; v.mis = m;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, plays the RAM (rdata lat cycles after mem_rd) and
  // checks strobes, timing and merged data on both endian instances.
  task automatic run_vec(vec_t v, string tag);
    int rd_n = 0, wr_n = 0, rd_cyc = -100, wr_cyc = -1, done_cyc = -1;
    logic err_seen = 1'b0;
    logic [31:0] ra = '0, wa = '0, wb = '0, wl = '0;
    req_valid = 1'b1; addr = v.addr; size = v.size; data_in = v.data; mem_rvalid = 1'b0;
    chk({tag, " ready"}, {31'd0, ifb.req_ready}, 32'd1);
    step();
    // Request fields change while req_valid stays high: all must be ignored.
    addr = 32'hFFFF_FFFF; size = 2'b00; data_in = 32'h5A5A_5A5A;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      mem_rvalid = 1'b0; mem_rdata = 32'hBAD0_BAD0;
      // Stray rvalid with junk data outside WAIT must not disturb anything.
      if (ifb.mem_rd) begin rd_n++; rd_cyc = cyc; ra = ifb.mem_addr; mem_rvalid = 1'b1; end
      if (ifb.mem_wr) begin wr_n++; wr_cyc = cyc; wa = ifb.mem_addr; wb = ifb.mem_wdata; mem_rvalid = 1'b1; end
      if (ifl.mem_wr) wl = ifl.mem_wdata;
      if (rd_cyc > 0 && cyc == rd_cyc + v.lat) begin mem_rvalid = 1'b1; mem_rdata = v.rdata; end
      if (ifb.done) begin done_cyc = cyc; err_seen = ifb.err; req_valid = 1'b0; end
      step();
    end
    req_valid = 1'b0; mem_rvalid = 1'b0;
    chk({tag, " idle_after"}, {30'd0, ifb.busy, ifb.req_ready}, 32'd1);
    if (TRAP_EN && v.mis) begin
      chk({tag, " trap_done_cyc"}, done_cyc, 32'd1);
      chk({tag, " trap_err"}, {31'd0, err_seen}, 32'd1);
      chk({tag, " trap_access"}, rd_n + wr_n, 32'd0);
    end else begin
      chk({tag, " err"}, {31'd0, err_seen}, 32'd0);
      chk({tag, " wr_n"}, wr_n, 32'd1);
      if (v.size[1]) begin
        chk({tag, " rd_n"}, rd_n, 32'd0);
        chk({tag, " wr_cyc"}, wr_cyc, 32'd1);
      end else begin
        chk({tag, " rd_n"}, rd_n, 32'd1);
        chk({tag, " rd_cyc"}, rd_cyc, 32'd1);
        chk({tag, " rd_addr"}, ra, v.exp_addr);
        chk({tag, " wr_cyc"}, wr_cyc, 1 + v.lat + 1);
      end
      chk({tag, " wr_addr"}, wa, v.exp_addr);
      chk({tag, " wdata_be"}, wb, v.exp_be);
      chk({tag, " wdata_le"}, wl, v.exp_le);
      chk({tag, " done_cyc"}, done_cyc, wr_cyc + 1);
    end
  endtask

  initial begin
    int wr_seen, done_seen;
    //             addr          size   data           rdata         lat addr          BE            LE            mis
    tbl[0] = mk(32'h0000_0008, 2'b10, 32'hDEAD_BEEF, 32'h0,        1, 32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    tbl[1] = mk(32'h0000_0005, 2'b00, 32'h1234_56AB, 32'h1122_3344, 3, 32'h0000_0004, 32'h11AB_3344, 32'h1122_AB44, 0);
    tbl[2] = mk(32'h0000_0002, 2'b01, 32'hFFFF_CAFE, 32'h0000_0000, 1, 32'h0000_0000, 32'h0000_CAFE, 32'hCAFE_0000, 0);
    tbl[3] = mk(32'h0000_0010, 2'b00, 32'h0000_00FF, 32'hAABB_CCDD, 2, 32'h0000_0010, 32'hFFBB_CCDD, 32'hAABB_CCFF, 0);
    tbl[4] = mk(32'h0000_0013, 2'b00, 32'h0000_0077, 32'h0000_0000, 1, 32'h0000_0010, 32'h0000_0077, 32'h7700_0000, 0);
    tbl[5] = mk(32'h0000_0020, 2'b01, 32'h1234_BEEF, 32'h5566_7788, 4, 32'h0000_0020, 32'hBEEF_7788, 32'h5566_BEEF, 0);
    tbl[6] = mk(32'h0000_000C, 2'b11, 32'hCAFE_F00D, 32'h0,        1, 32'h0000_000C, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
    tbl[7] = mk(32'h0000_0003, 2'b01, 32'h0000_CAFE, 32'h1122_3344, 1, 32'h0000_0000, 32'h1122_CAFE, 32'hCAFE_3344, 1);
    tbl[8] = mk(32'h0000_0006, 2'b10, 32'h0102_0304, 32'h0,        1, 32'h0000_0004, 32'h0102_0304, 32'h0102_0304, 1);

    // Reset held with a pending request: nothing may happen.
    rst = 1'b1; req_valid = 1'b1; addr = 32'h8; size = 2'b10; data_in = 32'hDEAD_BEEF;
    step(); step();
    chk("rst strobes", {27'd0, ifb.mem_rd, ifb.mem_wr, ifb.done, ifb.busy, ifb.err}, 32'd0);
    chk("rst mem_addr", ifb.mem_addr, 32'd0);
    chk("rst mem_wdata", ifb.mem_wdata, 32'd0);
    req_valid = 1'b0; rst = 1'b0;
    #1;
    chk("rst ready", {31'd0, ifb.req_ready}, 32'd1);
    step(); step();
    chk("rst no_access", {29'd0, ifb.mem_rd, ifb.mem_wr, ifb.busy}, 32'd0);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while in WAIT, then a late rvalid: no write, no done.
    req_valid = 1'b1; addr = 32'h5; size = 2'b00; data_in = 32'h1234_56AB;
    step();
    req_valid = 1'b0;
    chk("mid rd", {31'd0, ifb.mem_rd}, 32'd1);
    step();
    chk("mid wait", {30'd0, ifb.busy, ifb.mem_rd}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid rst_out", {28'd0, ifb.busy, ifb.mem_rd, ifb.mem_wr, ifb.done}, 32'd0);
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    wr_seen = 0; done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      mem_rvalid = 1'b0;
      wr_seen += ifb.mem_wr; done_seen += ifb.done;
    end
    chk("mid no_wr", wr_seen, 32'd0);
    chk("mid no_done", done_seen, 32'd0);
    run_vec(tbl[1], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
Store-side counterpart of the 16→32 load extend unit: narrows a 32-bit register value to byte, halfword or word and writes it into a 32-bit-wide data memory. Sub-word stores use a read-modify-write sequence; full-word stores write directly. Sits between the MIPS execute/memory stage (sb/sh/sw) and the word-addressed data RAM, with a valid/ready request handshake and a done pulse.

Parameters:
ADDR_W, 32, byte-address width of addr and mem_addr.
BIG_ENDIAN, 1, 1 = MIPS big-endian lane mapping; 0 = little-endian.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  store request present
req_ready  output  1  unit can accept a request (high only in IDLE)
addr  input  ADDR_W  byte address of store
size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
data_in  input  32  register value; low bits used for sub-word stores
mem_addr  output  ADDR_W  word address to RAM (addr with [1:0] = 00)
mem_rd  output  1  one-cycle read strobe
mem_rdata  input  32  read data from RAM
mem_rvalid  input  1  mem_rdata valid this cycle (latency ≥ 1 cycle)
mem_wr  output  1  one-cycle write strobe
mem_wdata  output  32  merged word to write
done  output  1  one-cycle pulse when the store completes
busy  output  1  high in every state except IDLE
err  output  1  one-cycle pulse with done on a rejected request (feature only)

Behaviour:
- Reset (async, rst=1): state IDLE; mem_rd, mem_wr, done, err, busy = 0; mem_addr, mem_wdata = 0; req_ready = 1 once rst deasserts. Internal request registers cleared.
- Handshake: request accepted on the rising edge where req_valid && req_ready. addr, size and data_in are captured in that cycle and ignored afterwards.
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE: on accept, word (size 10 or 11) → WR; byte/half → RD.
- RD: mem_rd = 1 for exactly one cycle, mem_addr = word address → WAIT.
- WAIT: hold mem_addr, mem_rd = 0; when mem_rvalid = 1, register the merged word → WR. Wait is unbounded.
- WR: mem_wr = 1 for one cycle with mem_addr and mem_wdata valid → DONE.
- DONE: done = 1 for one cycle → IDLE. req_ready rises in the cycle after done.
- Latency, word store: accept at edge 0; mem_wr high in cycle 1; done high in cycle 2.
- Latency, sub-word store: mem_rd in cycle 1; mem_wr in the cycle after mem_rvalid; done in the cycle after that.
- Lane mapping, BIG_ENDIAN = 1:
  - Byte: offset 0 → [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
  - Half: addr[1] = 0 → [31:16], 1 → [15:0].
- Lane mapping, BIG_ENDIAN = 0: mirrored (offset 0 → [7:0]; half addr[1] = 0 → [15:0]).
- Merge: only the target lane takes data_in[7:0] or data_in[15:0]; all other bits come from mem_rdata unchanged. The upper bits of data_in are discarded (truncation is the inverse of extension; no sign handling).
- Word store: mem_wdata = data_in; no read.
- size 11: treated as a word store.
- Boundary conditions:
  - mem_rvalid outside WAIT is ignored.
  - req_valid while busy is ignored; no queueing.
  - rst asserted mid-sequence aborts it: no write and no done; the state returns to IDLE.

Optional Feature:
Macro STORE_NARROW_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0] = 1 or a word with addr[1:0] ≠ 00 does no memory access. The unit goes IDLE → DONE with done = 1 and err = 1 in the same cycle.
- Not defined: err is tied to 0. Misaligned addresses are forced aligned: a halfword ignores addr[0]; a word ignores addr[1:0].

Test Plan:
- Reset: hold rst = 1 for 2 cycles with req_valid = 1 → mem_rd, mem_wr, done, busy all 0; req_ready = 1 after release; no memory access.
- Word store: addr 0x0000_0008, size 10, data_in 0xDEADBEEF → mem_wr in cycle 1 with mem_addr 0x8 and mem_wdata 0xDEADBEEF; done in cycle 2; mem_rd never asserted.
- Byte store (BE): addr 0x0000_0005, data_in 0x1234_56AB, mem_rdata 0x1122_3344 returned 3 cycles after mem_rd → mem_addr 0x4; mem_wdata 0x11AB_3344; done one cycle after mem_wr.
- Half store (BE): addr 0x0000_0002, data_in 0xFFFF_CAFE, mem_rdata 0x0000_0000 → mem_wdata 0x0000_CAFE. With BIG_ENDIAN = 0 → 0xCAFE_0000.
- Reset mid-operation: assert rst while in WAIT, then deliver mem_rvalid → no mem_wr and no done; the next request completes normally.
- Misaligned half, addr 0x3:
  - With macro: done = 1 and err = 1, no mem_rd/mem_wr.
  - Without macro: treated as addr 0x2 (BE lane [15:0]), err = 0.
